// File: rtl/ripple_count_extender.sv
`default_nettype none
// ============================================================================
// Module      : ripple_count_extender
// Description : Samples a free-running 4-bit ripple count into clk, accepts
//               only values seen identically on two consecutive edges, extends
//               the count to EXT_W bits with wrap/skip pulses and offers a
//               valid/ready snapshot port. Optional sticky overflow flag is
//               built when RIPPLE_EXT_OVF_STICKY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_count_extender #(
    parameter int EXT_W    = 16,
    parameter int MAX_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cnt_in,
    input  logic             snap_req,
    input  logic             snap_ready,
    output logic [3:0]       stab_cnt,
    output logic [EXT_W-1:0] ext_cnt,
    output logic             wrap_pulse,
    output logic             skip_err,
    output logic             snap_valid,
    output logic [EXT_W-1:0] snap_data,
    output logic             ext_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } snap_state_t;

`ifdef RIPPLE_EXT_OVF_STICKY_EN
    localparam int SUM_W = EXT_W + 1;
`else
    localparam int SUM_W = EXT_W;
`endif

    // Two-flop sampler; stage 1 may go metastable, stage 2 is only trusted
    // when it agrees with stage 1.
    logic [3:0]       s1_q, s2_q;
    logic [3:0]       stab_cnt_q, stab_cnt_d;
    logic [EXT_W-1:0] ext_cnt_q, ext_cnt_d;
    logic             first_q, first_d;
    logic             wrap_q, wrap_d;
    logic             skip_q, skip_d;
    snap_state_t      state_q, state_d;
    logic             snap_valid_q, snap_valid_d;
    logic [EXT_W-1:0] snap_data_q, snap_data_d;

    logic             w_accept;
    logic [3:0]       w_delta;
    logic [SUM_W-1:0] w_sum;

    assign w_accept = (s1_q == s2_q) && (s2_q != stab_cnt_q);
    assign w_delta  = s2_q - stab_cnt_q;
    assign w_sum    = SUM_W'(ext_cnt_q) + SUM_W'(w_delta);

    always_comb begin
        stab_cnt_d = stab_cnt_q;
        ext_cnt_d  = ext_cnt_q;
        first_d    = first_q;
        wrap_d     = 1'b0;
        skip_d     = 1'b0;
        if (w_accept) begin
            stab_cnt_d = s2_q;
            if (first_q) begin
                // First value after reset is taken as the absolute start point.
                ext_cnt_d = EXT_W'(s2_q);
                first_d   = 1'b0;
            end else begin
                ext_cnt_d = w_sum[EXT_W-1:0];
                wrap_d    = (s2_q < stab_cnt_q);
                skip_d    = (32'(w_delta) > MAX_STEP);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_data_d = snap_data_q;
        case (state_q)
            ST_IDLE: begin
                if (snap_req) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // Capture the post-edge count so a same-edge accept is included.
                snap_data_d = ext_cnt_d;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (snap_valid_q && snap_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        snap_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= 4'd0;
            s2_q         <= 4'd0;
            stab_cnt_q   <= 4'd0;
            ext_cnt_q    <= '0;
            first_q      <= 1'b1;
            wrap_q       <= 1'b0;
            skip_q       <= 1'b0;
            state_q      <= ST_IDLE;
            snap_valid_q <= 1'b0;
            snap_data_q  <= '0;
        end else begin
            s1_q         <= cnt_in;
            s2_q         <= s1_q;
            stab_cnt_q   <= stab_cnt_d;
            ext_cnt_q    <= ext_cnt_d;
            first_q      <= first_d;
            wrap_q       <= wrap_d;
            skip_q       <= skip_d;
            state_q      <= state_d;
            snap_valid_q <= snap_valid_d;
            snap_data_q  <= snap_data_d;
        end
    end

`ifdef RIPPLE_EXT_OVF_STICKY_EN
    logic ext_ovf_q, ext_ovf_d;

    always_comb begin
        ext_ovf_d = ext_ovf_q;
        if (w_accept && !first_q && w_sum[EXT_W]) begin
            ext_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_ovf_q <= 1'b0;
        end else begin
            ext_ovf_q <= ext_ovf_d;
        end
    end

    assign ext_ovf = ext_ovf_q;
`else
    assign ext_ovf = 1'b0;
`endif

    assign stab_cnt   = stab_cnt_q;
    assign ext_cnt    = ext_cnt_q;
    assign wrap_pulse = wrap_q;
    assign skip_err   = skip_q;
    assign snap_valid = snap_valid_q;
    assign snap_data  = snap_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_extender.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_count_extender
// Description : Random/directed bench for ripple_count_extender; two instances
//               (EXT_W=16 and EXT_W=5) share stimulus and are compared with an
//               arithmetic reference model. Honours RIPPLE_EXT_OVF_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_count_extender;

    localparam int W_A      = 16;
    localparam int W_B      = 5;
    localparam int MAX_STEP = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     cnt_in;
    logic           snap_req;
    logic           snap_ready;

    logic [3:0]     a_stab, b_stab;
    logic [W_A-1:0] a_ext, a_snap;
    logic [W_B-1:0] b_ext, b_snap;
    logic           a_wrap, a_skip, a_valid, a_ovf;
    logic           b_wrap, b_skip, b_valid, b_ovf;

    ripple_count_extender #(.EXT_W(W_A), .MAX_STEP(MAX_STEP)) dut_a (
        .clk(clk), .rst(rst), .cnt_in(cnt_in),
        .snap_req(snap_req), .snap_ready(snap_ready),
        .stab_cnt(a_stab), .ext_cnt(a_ext), .wrap_pulse(a_wrap),
        .skip_err(a_skip), .snap_valid(a_valid), .snap_data(a_snap),
        .ext_ovf(a_ovf)
    );

    ripple_count_extender #(.EXT_W(W_B), .MAX_STEP(MAX_STEP)) dut_b (
        .clk(clk), .rst(rst), .cnt_in(cnt_in),
        .snap_req(snap_req), .snap_ready(snap_ready),
        .stab_cnt(b_stab), .ext_cnt(b_ext), .wrap_pulse(b_wrap),
        .skip_err(b_skip), .snap_valid(b_valid), .snap_data(b_snap),
        .ext_ovf(b_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: total counts all accepted increments since reset.
    int m_stab, m_total, m_first, m_wrap, m_skip;
    int m_phase;            // 0 idle, 1 capturing this edge, 2 holding
    int m_cap;
    int h_last, h_prev;     // cnt_in seen at the last edge / the one before

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        m_stab = 0; m_total = 0; m_first = 1; m_wrap = 0; m_skip = 0;
        m_phase = 0; m_cap = 0; h_last = 0; h_prev = 0;
    endfunction

    function automatic void model_edge();
        int v;
        int d;
        m_wrap = 0;
        m_skip = 0;
        if (h_last == h_prev && h_prev != m_stab) begin
            v = h_prev;
            if (m_first != 0) begin
                m_total = v;
                m_first = 0;
            end else begin
                d = (v - m_stab + 16) % 16;
                m_total += d;
                m_wrap = (v < m_stab) ? 1 : 0;
                m_skip = (d > MAX_STEP) ? 1 : 0;
            end
            m_stab = v;
        end
        if (m_phase == 0) begin
            if (snap_req) m_phase = 1;
        end else if (m_phase == 1) begin
            m_cap   = m_total;
            m_phase = 2;
        end else if (snap_ready) begin
            m_phase = 0;
        end
        h_prev = h_last;
        h_last = int'(cnt_in);
    endfunction

    task automatic check_all();
        int ovf_a, ovf_b;
`ifdef RIPPLE_EXT_OVF_STICKY_EN
        ovf_a = (m_total >= (1 << W_A)) ? 1 : 0;
        ovf_b = (m_total >= (1 << W_B)) ? 1 : 0;
`else
        ovf_a = 0;
        ovf_b = 0;
`endif
        check_val("stab_a",  32'(a_stab),  32'(m_stab));
        check_val("stab_b",  32'(b_stab),  32'(m_stab));
        check_val("ext_a",   32'(a_ext),   32'(m_total % (1 << W_A)));
        check_val("ext_b",   32'(b_ext),   32'(m_total % (1 << W_B)));
        check_val("wrap_a",  32'(a_wrap),  32'(m_wrap));
        check_val("wrap_b",  32'(b_wrap),  32'(m_wrap));
        check_val("skip_a",  32'(a_skip),  32'(m_skip));
        check_val("skip_b",  32'(b_skip),  32'(m_skip));
        check_val("valid_a", 32'(a_valid), (m_phase == 2) ? 32'd1 : 32'd0);
        check_val("valid_b", 32'(b_valid), (m_phase == 2) ? 32'd1 : 32'd0);
        check_val("snap_a",  32'(a_snap),  32'(m_cap % (1 << W_A)));
        check_val("snap_b",  32'(b_snap),  32'(m_cap % (1 << W_B)));
        check_val("ovf_a",   32'(a_ovf),   32'(ovf_a));
        check_val("ovf_b",   32'(b_ovf),   32'(ovf_b));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic [3:0] c, input logic rq, input logic rd);
        cnt_in     = c;
        snap_req   = rq;
        snap_ready = rd;
        @(posedge clk);
        model_edge();
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] v;
        int r;
        rst        = 1'b1;
        cnt_in     = 4'd0;
        snap_req   = 1'b0;
        snap_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        repeat (4) cycle(4'd0, 1'b0, 1'b0);

        // Slow count through a full wrap
        for (int i = 1; i <= 17; i++) begin
            v = 4'(i % 16);
            repeat (8) cycle(v, 1'b0, 1'b0);
        end
        cur = 4'd1;

        // Snapshot held while counting continues, extra request ignored
        cycle(cur, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) cur = cur + 4'd1;
            cycle(cur, (i == 5) ? 1'b1 : 1'b0, 1'b0);
        end
        cycle(cur, 1'b1, 1'b1);
        repeat (3) cycle(cur, 1'b0, 1'b0);

        // Reset in the middle of a held snapshot
        cycle(cur, 1'b1, 1'b0);
        repeat (4) cycle(cur, 1'b0, 1'b0);
        do_reset();
        cur = 4'd0;

        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                v = 4'($urandom_range(0, 15));
                cycle(v, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0));
            end else begin
                if (r == 9) cur = cur + 4'($urandom_range(5, 15));
                else        cur = cur + 4'($urandom_range(0, MAX_STEP));
                repeat ($urandom_range(1, 6))
                    cycle(cur, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0));
            end
            if (it % 400 == 399) begin
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
